// File: rtl/z16_pkg.sv
// Shared Z16 definitions: instruction field positions, opcode width,
// the set of opcodes that write rd, and the instruction decode helper.
package z16_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned INST_W   = 16;

    // Instruction field positions
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 4;
    localparam int unsigned RS1_LSB    = 8;
    localparam int unsigned RS2_LSB    = 12;
    localparam int unsigned IMM_LSB    = 8;
    localparam int unsigned IMM_W      = 8;

    // Bit n set: opcode n writes its rd field (opcodes 0-8).
    localparam logic [15:0] WRITES_RD_MASK = 16'h01FF;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [REG_W-1:0]    reg_addr_t;
    typedef logic [DATA_W-1:0]   data_t;

    typedef struct packed {
        opcode_t   opcode;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        data_t     imm;
        logic      writes_rd;
    } dec_t;

    // Split an instruction into its fields; imm8 is sign-extended to DATA_W.
    function automatic dec_t decode(input logic [INST_W-1:0] inst);
        dec_t d;
        d.opcode    = inst[OPCODE_LSB +: OPCODE_W];
        d.rd        = inst[RD_LSB +: REG_W];
        d.rs1       = inst[RS1_LSB +: REG_W];
        d.rs2       = inst[RS2_LSB +: REG_W];
        d.imm       = {{(DATA_W - IMM_W){inst[IMM_LSB + IMM_W - 1]}},
                       inst[IMM_LSB +: IMM_W]};
        d.writes_rd = WRITES_RD_MASK[d.opcode];
        return d;
    endfunction

endpackage

// File: rtl/z16_scoreboard.sv
// Outstanding-write scoreboard: one busy bit per architectural register.
// A set (issue) and up to two clears (writeback, flush of the held payload)
// may arrive in the same cycle; the set takes priority on a shared bit.
module z16_scoreboard
    import z16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic             wb_clr_en,
    input  logic [REG_W-1:0] wb_clr_addr,
    input  logic             flush_clr_en,
    input  logic [REG_W-1:0] flush_clr_addr,
    input  logic [REG_W-1:0] rs1_addr,
    input  logic [REG_W-1:0] rs2_addr,
    input  logic [REG_W-1:0] rd_addr,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy,
    output logic             wb_clears_rs1,
    output logic             wb_clears_rs2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next-state: apply clears first so a same-bit set overrides them.
    always_comb begin
        busy_d = busy_q;
        if (wb_clr_en) begin
            busy_d[wb_clr_addr] = 1'b0;
        end
        if (flush_clr_en) begin
            busy_d[flush_clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Busy-bit state; reset forgets every outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups against the registered state plus "being cleared now" flags
    // used by the bypass path.
    always_comb begin
        rs1_busy      = busy_q[rs1_addr];
        rs2_busy      = busy_q[rs2_addr];
        rd_busy       = busy_q[rd_addr];
        wb_clears_rs1 = wb_clr_en && (wb_clr_addr == rs1_addr) && busy_q[rs1_addr];
        wb_clears_rs2 = wb_clr_en && (wb_clr_addr == rs2_addr) && busy_q[rs2_addr];
    end

endmodule

// File: rtl/z16_operand_fetch.sv
// Z16 operand-fetch stage: decodes an instruction, reads both source
// operands, tracks outstanding register writes to stall RAW/WAW hazards and
// registers the execute-stage payload with a valid/ready handshake.
// Optional build macro Z16_OF_BYPASS_EN forwards same-cycle writeback data
// into the operands and lets that writeback lift the RAW hazard at once;
// when undefined the hazard holds through the writeback cycle.
module z16_operand_fetch
    import z16_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_valid,
    output logic              o_inst_ready,
    input  logic [INST_W-1:0] i_inst,
    output logic [REG_W-1:0]  o_rs1_addr,
    output logic [REG_W-1:0]  o_rs2_addr,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic              i_wb_wen,
    input  logic [REG_W-1:0]  i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_flush,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [OPCODE_W-1:0] o_ex_opcode,
    output logic [REG_W-1:0]  o_ex_rd,
    output logic              o_ex_rd_wen,
    output logic [DATA_W-1:0] o_ex_op1,
    output logic [DATA_W-1:0] o_ex_op2,
    output logic [DATA_W-1:0] o_ex_imm,
    output logic              o_stall
);

    dec_t              dec;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              wb_clears_rs1;
    logic              wb_clears_rs2;
    logic              raw_hazard;
    logic              waw_hazard;
    logic              hazard;
    logic              fire_in;
    logic              flush_clr_en;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    // Execute-stage payload registers
    logic                ex_valid_q;
    logic [OPCODE_W-1:0] ex_opcode_q;
    logic [REG_W-1:0]    ex_rd_q;
    logic                ex_rd_wen_q;
    logic [DATA_W-1:0]   ex_op1_q;
    logic [DATA_W-1:0]   ex_op2_q;
    logic [DATA_W-1:0]   ex_imm_q;

    // Field decode of the incoming instruction.
    always_comb begin
        dec = decode(i_inst);
    end

    assign o_rs1_addr = dec.rs1;
    assign o_rs2_addr = dec.rs2;

    // A flushed payload that was going to write rd no longer will.
    assign flush_clr_en = i_flush && ex_valid_q && ex_rd_wen_q;

    z16_scoreboard u_scoreboard (
        .clk            (i_clk),
        .rst_n          (i_rst_n),
        .set_en         (fire_in && dec.writes_rd),
        .set_addr       (dec.rd),
        .wb_clr_en      (i_wb_wen),
        .wb_clr_addr    (i_wb_addr),
        .flush_clr_en   (flush_clr_en),
        .flush_clr_addr (ex_rd_q),
        .rs1_addr       (dec.rs1),
        .rs2_addr       (dec.rs2),
        .rd_addr        (dec.rd),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .rd_busy        (rd_busy),
        .wb_clears_rs1  (wb_clears_rs1),
        .wb_clears_rs2  (wb_clears_rs2)
    );

`ifdef Z16_OF_BYPASS_EN
    // Hazard and operand select with same-cycle writeback forwarding.
    always_comb begin
        raw_hazard = (rs1_busy && !wb_clears_rs1) || (rs2_busy && !wb_clears_rs2);
        op1 = (i_wb_wen && (i_wb_addr == dec.rs1)) ? i_wb_data : i_rs1_data;
        op2 = (i_wb_wen && (i_wb_addr == dec.rs2)) ? i_wb_data : i_rs2_data;
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wb_clears_rs1, wb_clears_rs2, i_wb_data};

    // Hazard and operand select; writeback only takes effect next cycle.
    always_comb begin
        raw_hazard = rs1_busy || rs2_busy;
        op1 = i_rs1_data;
        op2 = i_rs2_data;
    end
`endif

    // WAW is never bypassed; handshake and stall flag.
    always_comb begin
        waw_hazard   = dec.writes_rd && rd_busy;
        hazard       = raw_hazard || waw_hazard;
        o_inst_ready = !hazard && !i_flush && (!ex_valid_q || i_ex_ready);
        fire_in      = i_inst_valid && o_inst_ready;
        o_stall      = i_inst_valid && hazard;
    end

    // Payload register: load on accept, drop on flush or consume, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_rd_q     <= '0;
            ex_rd_wen_q <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_imm_q    <= '0;
        end else if (fire_in) begin
            ex_valid_q  <= 1'b1;
            ex_opcode_q <= dec.opcode;
            ex_rd_q     <= dec.rd;
            ex_rd_wen_q <= dec.writes_rd;
            ex_op1_q    <= op1;
            ex_op2_q    <= op2;
            ex_imm_q    <= dec.imm;
        end else if (i_flush || i_ex_ready) begin
            ex_valid_q  <= 1'b0;
        end
    end

    assign o_ex_valid  = ex_valid_q;
    assign o_ex_opcode = ex_opcode_q;
    assign o_ex_rd     = ex_rd_q;
    assign o_ex_rd_wen = ex_rd_wen_q;
    assign o_ex_op1    = ex_op1_q;
    assign o_ex_op2    = ex_op2_q;
    assign o_ex_imm    = ex_imm_q;

endmodule

// File: tb/tb_z16_operand_fetch.sv
// Testbench for z16_operand_fetch: directed instructions, expected execute
// payloads queued at issue and compared by an independent monitor whenever
// the execute stage consumes a payload; hazard, stall, scoreboard and reset
// behaviour are checked directly by the stimulus process.
module tb_z16_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        wb_wen;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic        ex_rd_wen;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [15:0] ex_imm;
    logic        stall;

    logic [15:0] rf [16];
    logic [15:0] sb;
    logic [56:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    z16_operand_fetch dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst_valid (inst_valid),
        .o_inst_ready (inst_ready),
        .i_inst       (inst),
        .o_rs1_addr   (rs1_addr),
        .o_rs2_addr   (rs2_addr),
        .i_rs1_data   (rs1_data),
        .i_rs2_data   (rs2_data),
        .i_wb_wen     (wb_wen),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_flush      (flush),
        .o_ex_valid   (ex_valid),
        .i_ex_ready   (ex_ready),
        .o_ex_opcode  (ex_opcode),
        .o_ex_rd      (ex_rd),
        .o_ex_rd_wen  (ex_rd_wen),
        .o_ex_op1     (ex_op1),
        .o_ex_op2     (ex_op2),
        .o_ex_imm     (ex_imm),
        .o_stall      (stall)
    );

    assign sb = dut.u_scoreboard.busy_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: combinational read, write on the writeback port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 + 16'(i);
            rf[3] <= 16'h1234;
        end else if (wb_wen) begin
            rf[wb_addr] <= wb_data;
        end
    end
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [56:0] payload(input logic [3:0] opc, input logic [3:0] rd,
                                            input logic wen, input logic [15:0] op1,
                                            input logic [15:0] op2, input logic [15:0] imm);
        return {opc, rd, wen, op1, op2, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until accepted; optionally queue its payload.
    task automatic issue(input logic [15:0] i, input logic push, input logic [56:0] exp);
        int n;
        inst_valid = 1'b1;
        inst       = i;
        n          = 0;
        @(negedge clk);
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", 64'(inst_ready), 64'(1'b1));
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
    endtask

    // Monitor: compare every consumed payload against the queue head.
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_payload", 64'(1'b1), 64'(1'b0));
            end else begin
                check("ex_payload",
                      64'({ex_opcode, ex_rd, ex_rd_wen, ex_op1, ex_op2, ex_imm}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 16'h0000;
        wb_wen     = 1'b0;
        wb_addr    = 4'h0;
        wb_data    = 16'h0000;
        flush      = 1'b0;
        ex_ready   = 1'b1;

        // Reset state
        #3;
        check("rst_ex_valid", 64'(ex_valid), 64'(1'b0));
        check("rst_ready", 64'(inst_ready), 64'(1'b1));
        check("rst_stall", 64'(stall), 64'(1'b0));
        check("rst_sb", 64'(sb), 64'(16'h0000));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Simple issue: 0A31 -> opcode 1, rd 3, rs1 R10, rs2 R0, imm 000A
        inst = 16'h0A31;
        @(negedge clk);
        check("rs1_addr", 64'(rs1_addr), 64'(4'hA));
        check("rs2_addr", 64'(rs2_addr), 64'(4'h0));
        tick();
        issue(16'h0A31, 1'b1, payload(4'h1, 4'h3, 1'b1, 16'h100A, 16'h1000, 16'h000A));
        @(negedge clk);
        check("issue_ex_valid", 64'(ex_valid), 64'(1'b1));
        check("issue_sb", 64'(sb), 64'(16'h0008));
        tick();
        tick();

        // RAW on R3: 0342 -> opcode 2, rd 4, rs1 R3, rs2 R0, imm 0003
        inst_valid = 1'b1;
        inst       = 16'h0342;
        @(negedge clk);
        check("raw_stall0", 64'({stall, inst_ready}), 64'(2'b10));
        tick();
        @(negedge clk);
        check("raw_stall1", 64'({stall, inst_ready}), 64'(2'b10));
        tick();
        wb_wen  = 1'b1;
        wb_addr = 4'h3;
        wb_data = 16'h5555;
        @(negedge clk);
`ifdef Z16_OF_BYPASS_EN
        check("raw_wb_cycle", 64'({stall, inst_ready}), 64'(2'b01));
        exp_q.push_back(payload(4'h2, 4'h4, 1'b1, 16'h5555, 16'h1000, 16'h0003));
        tick();
        wb_wen     = 1'b0;
        inst_valid = 1'b0;
`else
        check("raw_wb_cycle", 64'({stall, inst_ready}), 64'(2'b10));
        tick();
        wb_wen = 1'b0;
        @(negedge clk);
        check("raw_after_wb", 64'({stall, inst_ready}), 64'(2'b01));
        exp_q.push_back(payload(4'h2, 4'h4, 1'b1, 16'h5555, 16'h1000, 16'h0003));
        tick();
        inst_valid = 1'b0;
`endif
        @(negedge clk);
        check("raw_sb", 64'(sb), 64'(16'h0010));
        tick();
        tick();

        // Backpressure: F065 held for 3 cycles while 8179 waits
        ex_ready = 1'b0;
        issue(16'hF065, 1'b1, payload(4'h5, 4'h6, 1'b1, 16'h1000, 16'h100F, 16'hFFF0));
        inst_valid = 1'b1;
        inst       = 16'h8179;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", 64'(inst_ready), 64'(1'b0));
            check("bp_hold",
                  64'({ex_valid, ex_opcode, ex_rd, ex_rd_wen, ex_op1, ex_op2, ex_imm}),
                  64'({1'b1, payload(4'h5, 4'h6, 1'b1, 16'h1000, 16'h100F, 16'hFFF0)}));
            tick();
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", 64'(inst_ready), 64'(1'b1));
        exp_q.push_back(payload(4'h9, 4'h7, 1'b0, 16'h1001, 16'h1008, 16'hFF81));
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        check("bp_sb", 64'(sb), 64'(16'h0050));
        tick();

        // Same-cycle writeback and issue to R5: set wins
        wb_wen  = 1'b1;
        wb_addr = 4'h5;
        wb_data = 16'hBEEF;
        issue(16'h0050, 1'b1, payload(4'h0, 4'h5, 1'b1, 16'h1000, 16'h1000, 16'h0000));
        wb_wen = 1'b0;
        @(negedge clk);
        check("setclr_sb", 64'(sb), 64'(16'h0070));
        tick();
        wb_wen  = 1'b1;
        wb_addr = 4'h4;
        tick();
        wb_addr = 4'h9;
        @(negedge clk);
        check("wb_clear_sb", 64'(sb), 64'(16'h0060));
        tick();
        wb_wen = 1'b0;
        @(negedge clk);
        check("wb_idle_reg_sb", 64'(sb), 64'(16'h0060));
        tick();

        // WAW on R6: 0061 waits for the R6 writeback
        inst_valid = 1'b1;
        inst       = 16'h0061;
        @(negedge clk);
        check("waw_stall", 64'({stall, inst_ready}), 64'(2'b10));
        tick();
        wb_wen  = 1'b1;
        wb_addr = 4'h6;
        wb_data = 16'h6666;
        tick();
        wb_wen = 1'b0;
        issue(16'h0061, 1'b1, payload(4'h1, 4'h6, 1'b1, 16'h1000, 16'h1000, 16'h0000));
        repeat (2) tick();

        // Flush of a held instruction writing R7
        ex_ready = 1'b0;
        issue(16'h0077, 1'b0, '0);
        @(negedge clk);
        check("flush_pre_valid", 64'(ex_valid), 64'(1'b1));
        check("flush_pre_sb", 64'(sb), 64'(16'h00E0));
        tick();
        flush      = 1'b1;
        inst_valid = 1'b1;
        inst       = 16'h0090;
        @(negedge clk);
        check("flush_ready", 64'(inst_ready), 64'(1'b0));
        tick();
        flush      = 1'b0;
        inst_valid = 1'b0;
        @(negedge clk);
        check("flush_ex_valid", 64'(ex_valid), 64'(1'b0));
        check("flush_sb", 64'(sb), 64'(16'h0060));
        tick();

        // Reset asserted while a payload is held
        issue(16'h0082, 1'b0, '0);
        @(negedge clk);
        check("midrst_pre_valid", 64'(ex_valid), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ex_valid", 64'(ex_valid), 64'(1'b0));
        check("midrst_sb", 64'(sb), 64'(16'h0000));
        check("midrst_ready_stall", 64'({inst_ready, stall}), 64'(2'b10));
        tick();
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        repeat (3) tick();

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
